// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/subtract and a shift-add multiplier that
// produces one partial product per clock, with ready/done handshaking.
package Types;
   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2
   } sel_t;

   typedef logic [1:0] mode_t;
endpackage

module seq_alu
   import Types::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic                 Start,
   output logic                 Ready,
   input  logic [WIDTH-1:0]     Op1,
   input  logic [WIDTH-1:0]     Op2,
   input  sel_t                 Sel,
   input  logic                 C_In,
   input  mode_t                Mode,
   output logic [2*WIDTH-1:0]   Result,
   output logic                 Equal,
   output logic                 Done
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       count_reg;
   logic [CW-1:0]       count_next;
   logic [RW-1:0]       acc_reg;
   logic [RW-1:0]       acc_next;
   logic [RW-1:0]       mcand_reg;
   logic [WIDTH-1:0]    mplier_reg;
   logic [RW-1:0]       result_reg;
   logic                equal_reg;
   logic                done_reg;

   logic                accept;
   logic                last_step;
   logic                cin_eff;
   logic [RW-1:0]       op1_ext, op2_ext, cin_ext;
   logic [RW-1:0]       add_val, sub_val;

   assign accept    = Start && Ready;
   assign last_step = (count_reg == CW'(WIDTH - 1));
   assign count_next = count_reg + CW'(1);

   // Carry/borrow-in only participates when Mode is nonzero.
   assign cin_eff = C_In & (|Mode);
   assign op1_ext = {{WIDTH{1'b0}}, Op1};
   assign op2_ext = {{WIDTH{1'b0}}, Op2};
   assign cin_ext = {{(RW-1){1'b0}}, cin_eff};
   assign add_val = op1_ext + op2_ext + cin_ext;
   assign sub_val = op1_ext - op2_ext - cin_ext;

   assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : {RW{1'b0}});

   // State register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (Start) begin
               state_next = (Sel == MUL) ? MULT : DONE;
            end else if (state_reg == DONE) begin
               state_next = IDLE;
            end
         end
         MULT: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      Ready = 1'b0;
      if (state_reg != MULT) begin
         Ready = 1'b1;
      end
   end

   // Datapath: operands are captured at accept so later input changes are harmless.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         count_reg  <= '0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         result_reg <= '0;
         equal_reg  <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (accept) begin
            equal_reg  <= (Op1 == Op2);
            mcand_reg  <= op1_ext;
            mplier_reg <= Op2;
            acc_reg    <= '0;
            count_reg  <= '0;
            case (Sel)
               ADD: begin
                  result_reg <= add_val;
                  done_reg   <= 1'b1;
               end
               SUB: begin
                  result_reg <= sub_val;
                  done_reg   <= 1'b1;
               end
               MUL: begin
                  // Result holds its previous value until the product is ready.
               end
               default: begin
                  result_reg <= '0;
                  done_reg   <= 1'b1;
               end
            endcase
         end else if (state_reg == MULT) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_next;
            if (last_step) begin
               result_reg <= acc_next;
               done_reg   <= 1'b1;
            end
         end
      end
   end

   assign Result = result_reg;
   assign Equal  = equal_reg;
   assign Done   = done_reg;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the operand width in bits; legal values are 2 to 32.
REQ-002: Port Clock, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003: Port Reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004: Port Start, input, 1 bit, SHALL request a new operation.
REQ-005: Port Ready, output, 1 bit, SHALL indicate that Start will be accepted this cycle.
REQ-006: Ports Op1 and Op2, input, WIDTH bits each, SHALL carry the unsigned operands.
REQ-007: Port Sel, input, sel_t from package Types, SHALL select the operation: ADD, SUB, MUL, or any other value.
REQ-008: Port C_In, input, 1 bit, SHALL be the carry-in/borrow-in.
REQ-009: Port Mode, input, mode_t from package Types, SHALL enable C_In when nonzero.
REQ-010: Port Result, output, 2*WIDTH bits, SHALL be the registered result.
REQ-011: Port Equal, output, 1 bit, SHALL be the registered flag (Op1 == Op2) of the last accepted operation.
REQ-012: Port Done, output, 1 bit, SHALL be a one-cycle pulse marking Result as newly valid.

Function
REQ-013: The block SHALL implement states IDLE, MULT and DONE.
REQ-014: Ready SHALL be 1 only in IDLE and DONE.
REQ-015: A rising edge with Start=1 and Ready=1 is the accept edge; at that edge the block SHALL capture Op1, Op2, Sel, C_In and Mode and SHALL update Equal.
REQ-016: ADD SHALL produce Result = Op1 + Op2 + (C_In if Mode != 0), zero-extended, with carry-out at bit WIDTH.
REQ-017: SUB SHALL produce Result = Op1 - Op2 - (C_In if Mode != 0), modulo 2^(2*WIDTH), so negative values wrap.
REQ-018: For ADD, SUB and unsupported Sel values, the block SHALL write Result at the accept edge and go to DONE.
REQ-019: An unsupported Sel value SHALL produce Result = 0.
REQ-020: MUL SHALL produce the full unsigned product Op1 * Op2 in 2*WIDTH bits using a shift-add datapath, one partial product per cycle; Mode and C_In SHALL be ignored.
REQ-021: On MUL accept the block SHALL enter MULT with the cycle counter at 0 and SHALL clear its internal accumulator; Result SHALL hold its previous value.
REQ-022: The counter SHALL increment once per edge in MULT; at the WIDTH-th edge after accept, Result SHALL load the product and the state SHALL go to DONE.
REQ-023: Done SHALL be 1 exactly in the cycle following the edge that wrote Result, and 0 otherwise.
REQ-024: In DONE, Start=1 SHALL be accepted, back to back, and the state SHALL go to MULT or DONE per Sel; with Start=0 the state SHALL go to IDLE.
REQ-025: Start SHALL be ignored in MULT, with inputs neither captured nor queued.
REQ-026: Result and Equal SHALL hold until the next completion or accept respectively.
REQ-027: Operand changes after the accept edge SHALL NOT affect an operation in progress.
REQ-028: An accepted MUL SHALL therefore take WIDTH+1 cycles from accept to Done; ADD and SUB SHALL take 1.

Reset
REQ-029: While Reset_n=0: state = IDLE, counter = 0, accumulator = 0, Result = 0, Equal = 0, Done = 0, Ready = 1.
REQ-030: Reset asserted mid-MULT SHALL abort the operation immediately, with no Done pulse.
REQ-031: After Reset_n deasserts, the first rising edge with Start=1 SHALL be a valid accept.

Verification
REQ-032: Bench (WIDTH=8) SHALL cover: ADD 0xFF + 0x01, Mode=1, C_In=1 -> Result 0x0101, Done one cycle after accept, Equal 0.
REQ-033: Bench SHALL cover: SUB 0x03 - 0x05, Mode=0 -> Result 0xFFFE; SUB 0x07 - 0x07, Mode=1, C_In=1 -> Result 0xFFFF, Equal 1.
REQ-034: Bench SHALL cover: MUL 0xFF * 0xFF -> Ready low for 8 cycles, Result 0xFE01, with Done in the 9th cycle after accept.
REQ-035: Bench SHALL cover: Start=1 with ADD 1+1 during MULT -> ignored, with the MUL result unchanged and only one Done.
REQ-036: Bench SHALL cover: Reset_n pulsed low at MULT cycle 4 -> Result 0, no Done, Ready 1; a following ADD 2+3 -> 0x0005.
REQ-037: Bench SHALL cover: back-to-back operations with Start held high in DONE (ADD, then MUL 0x0C * 0x0A) -> 0x0078 after 8 more MULT cycles, and Sel=unsupported -> Result 0 with Done.
